// File: rtl/dsp_sched_pkg.sv
// dsp_sched_pkg: shared widths, latencies, FSM states and tag type for the DSP slice scheduler
package dsp_sched_pkg;

    localparam int A_W       = 18;
    localparam int C_W       = 48;
    localparam int P_W       = 48;
    localparam int SLICE_LAT = 4;
    localparam int C_SKEW    = 2;
    localparam int TAG_ID_W  = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/dsp_slice_scheduler_arbiter.sv
// dsp_rr_arbiter: one-hot round-robin grant after last_grant; prio_en lets requester 0 pre-empt (driven under DSP_SCHED_PRIO_EN)
module dsp_rr_arbiter
    import dsp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               prio_en,
    output logic [NUM_REQ-1:0] gnt
);

    logic [ID_W-1:0] idx;
    logic            found;

    // first active requester after last_grant wins; requester 0 is taken out of the rotation when it has priority
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req[idx] && !(prio_en && idx == '0)) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        if (prio_en && req[0]) gnt = NUM_REQ'(1);
    end

endmodule

// File: rtl/dsp_slice_scheduler.sv
// dsp_slice_scheduler: round-robin sharing of one 4-stage multiply-add slice; DSP_SCHED_PRIO_EN gives requester 0 strict priority
module dsp_slice_scheduler
    import dsp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sched_en,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*A_W-1:0] req_b,
    input  logic [NUM_REQ*A_W-1:0] req_d,
    input  logic [NUM_REQ*C_W-1:0] req_c,
    output logic [A_W-1:0]         dsp_a,
    output logic [A_W-1:0]         dsp_b,
    output logic [A_W-1:0]         dsp_d,
    output logic [C_W-1:0]         dsp_c,
    input  logic [P_W-1:0]         dsp_p,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [P_W-1:0]         rsp_p,
    output logic                   busy
);

    sched_state_t    state_q, state_d;
    logic [ID_W-1:0] last_q, last_d, gid;
    logic [2:0]      cnt_q, cnt_d;
    logic [A_W-1:0]  a_q, a_d, b_q, b_d, d_q, d_d;
    logic [C_W-1:0]  c_d;
    logic [C_W-1:0]  c_q [C_SKEW+1];
    tag_t            tag_d;
    tag_t            tag_q [SLICE_LAT+1];
    logic [NUM_REQ-1:0] gnt;
    logic            xfer, rsp_any, prio_en;

`ifdef DSP_SCHED_PRIO_EN
    assign prio_en = 1'b1;
`else
    assign prio_en = 1'b0;
`endif

    dsp_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .prio_en    (prio_en),
        .gnt        (gnt)
    );

    assign req_ready = (state_q == RUN && sched_en) ? gnt : '0;

    // mux the granted operands into the slice registers; bubbles load zeros
    always_comb begin
        a_d = '0;
        b_d = '0;
        d_d = '0;
        c_d = '0;
        gid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                a_d = req_a[i*A_W +: A_W];
                b_d = req_b[i*A_W +: A_W];
                d_d = req_d[i*A_W +: A_W];
                c_d = req_c[i*C_W +: C_W];
                gid = ID_W'(i);
            end
        end
        xfer       = |(req_ready & req_valid);
        tag_d.valid = xfer;
        tag_d.id    = xfer ? TAG_ID_W'(gid) : '0;
        last_d     = (xfer && !(prio_en && gid == '0)) ? gid : last_q;
    end

    // decode the oldest chain stage into a one-hot result strobe
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] = tag_q[SLICE_LAT].valid && tag_q[SLICE_LAT].id == TAG_ID_W'(i);
    end

    // in-flight accounting and IDLE/RUN/DRAIN sequencing; uses the post-update count so busy drops with the move to IDLE
    always_comb begin
        rsp_any = tag_q[SLICE_LAT].valid;
        cnt_d   = cnt_q + 3'(xfer) - 3'(rsp_any);
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = sched_en ? RUN : IDLE;
            RUN:     state_d = sched_en ? RUN : (cnt_d != '0 ? DRAIN : IDLE);
            DRAIN:   state_d = sched_en ? RUN : (cnt_d == '0 ? IDLE : DRAIN);
            default: state_d = IDLE;
        endcase
    end

    // state, operand registers and the tag/C chain; stage s holds the op accepted s edges ago
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= ID_W'(NUM_REQ-1);
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            for (int s = 0; s <= SLICE_LAT; s++) tag_q[s] <= '0;
            for (int s = 0; s <= C_SKEW; s++) c_q[s] <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            tag_q[0] <= tag_d;
            for (int s = 1; s <= SLICE_LAT; s++) tag_q[s] <= tag_q[s-1];
            c_q[0]   <= c_d;
            for (int s = 1; s <= C_SKEW; s++) c_q[s] <= c_q[s-1];
        end
    end

    assign dsp_a = a_q;
    assign dsp_b = b_q;
    assign dsp_d = d_q;
    assign dsp_c = c_q[C_SKEW];
    assign rsp_p = dsp_p;
    assign busy  = (cnt_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_dsp_slice_scheduler.sv
// tb_dsp_slice_scheduler: directed stimulus with a cycle-slot result model and literal spot checks
module tb_dsp_slice_scheduler;
    import dsp_sched_pkg::*;

    localparam int N = 4;

    logic clk = 0, rst_n = 0, sched_en = 0;
    logic [N-1:0] req_valid = '0, req_ready, rsp_valid;
    logic [N*A_W-1:0] req_a = '0, req_b = '0, req_d = '0;
    logic [N*C_W-1:0] req_c = '0;
    logic [A_W-1:0] dsp_a, dsp_b, dsp_d;
    logic [C_W-1:0] dsp_c;
    logic [P_W-1:0] dsp_p, rsp_p;
    logic busy;
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;

    dsp_slice_scheduler #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_d(req_d), .req_c(req_c),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
        .dsp_p(dsp_p), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
    );

    // DSP48A1 ADD-mode slice: A0/B0/D regs, pre-adder + A1, M and C regs, P reg
    logic [A_W-1:0] a0, b0, d0, a1, pre;
    logic [35:0] m;
    logic [C_W-1:0] c_r;
    logic [P_W-1:0] p_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0 <= '0; b0 <= '0; d0 <= '0; a1 <= '0; pre <= '0; m <= '0; c_r <= '0; p_r <= '0;
        end else begin
            a0 <= dsp_a; b0 <= dsp_b; d0 <= dsp_d;
            a1 <= a0; pre <= d0 + b0;
            m <= a1 * pre; c_r <= dsp_c;
            p_r <= P_W'(m) + c_r;
        end
    end
    assign dsp_p = p_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // model: a grant is legal when sched_en was high at the last edge and is still high
    logic en_last;
    always @(posedge clk or negedge rst_n) en_last <= !rst_n ? 1'b0 : sched_en;
    always @(posedge clk) cyc++;

    logic [N-1:0]   exp_rv [16];
    logic [P_W-1:0] exp_p  [16];
    logic [A_W-1:0] exp_a  [16], exp_b [16], exp_d [16];
    logic [C_W-1:0] exp_c  [16];
    int inflight = 0, last_m = N-1;

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g = '0;
        if (!(en_last && sched_en) || req_valid == '0) return '0;
`ifdef DSP_SCHED_PRIO_EN
        if (req_valid[0]) return N'(1);
`endif
        for (int i = 1; i <= N; i++) begin
            int j = (last_m + i) % N;
`ifdef DSP_SCHED_PRIO_EN
            if (j == 0) continue;
`endif
            if (req_valid[j]) begin
                g[j] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // single compare process: every cycle the outputs are checked against the slot model
    always @(negedge clk) begin
        logic [N-1:0] g;
        int s;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                exp_rv[i] = '0; exp_p[i] = '0; exp_a[i] = '0; exp_b[i] = '0; exp_d[i] = '0; exp_c[i] = '0;
            end
            inflight = 0;
            last_m = N-1;
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_p", rsp_p, 0);
            chk("rst_dsp_abd", {dsp_a, dsp_b, dsp_d}, 0);
            chk("rst_dsp_c", dsp_c, 0);
            chk("rst_busy", busy, 0);
        end else begin
            s = cyc % 16;
            g = model_grant();
            chk("ready", req_ready, g);
            chk("busy", busy, en_last || inflight > 0);
            chk("rsp_valid", rsp_valid, exp_rv[s]);
            if (exp_rv[s] != '0) begin
                chk("rsp_p", rsp_p, exp_p[s]);
                inflight--;
            end
            chk("dsp_a", dsp_a, exp_a[s]);
            chk("dsp_b", dsp_b, exp_b[s]);
            chk("dsp_d", dsp_d, exp_d[s]);
            chk("dsp_c", dsp_c, exp_c[s]);
            exp_rv[s] = '0; exp_p[s] = '0; exp_a[s] = '0; exp_b[s] = '0; exp_d[s] = '0; exp_c[s] = '0;
            if (g != '0) begin
                int id;
                logic [63:0] a, b, d, c;
                id = 0;
                for (int i = 0; i < N; i++) if (g[i]) id = i;
                a = 64'(req_a[id*A_W +: A_W]);
                b = 64'(req_b[id*A_W +: A_W]);
                d = 64'(req_d[id*A_W +: A_W]);
                c = 64'(req_c[id*C_W +: C_W]);
                exp_a[(cyc+1)%16] = A_W'(a);
                exp_b[(cyc+1)%16] = A_W'(b);
                exp_d[(cyc+1)%16] = A_W'(d);
                exp_c[(cyc+3)%16] = C_W'(c);
                exp_rv[(cyc+5)%16] = g;
                exp_p[(cyc+5)%16] = P_W'(a * (d + b) + c);
                inflight++;
`ifdef DSP_SCHED_PRIO_EN
                if (id != 0) last_m = id;
`else
                last_m = id;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b, input int d, input int c);
        req_a[i*A_W +: A_W] = A_W'(a);
        req_b[i*A_W +: A_W] = A_W'(b);
        req_d[i*A_W +: A_W] = A_W'(d);
        req_c[i*C_W +: C_W] = C_W'(c);
    endtask

    task automatic issue(input int i, input int a, input int b, input int d, input int c);
        logic got;
        got = 1'b0;
        set_ops(i, a, b, d, c);
        req_valid[i] = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = req_ready[i];
        end
        chk("issue_grant", got, 1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("lit_rst_busy", busy, 0);
        tick();
        rst_n = 1;
        sched_en = 1;
        tick();

        // single op: 2*(5+3)+10 = 26, four cycles after accept
        issue(2, 2, 3, 5, 10);
        repeat (4) @(negedge clk);
        chk("single_early", rsp_valid, 0);
        @(negedge clk);
        chk("single_rv", rsp_valid, 4'b0100);
        chk("single_p", rsp_p, 26);

        // all four requesters continuously valid; rotation starts after last grant (2)
        for (int i = 0; i < N; i++) set_ops(i, i+1, i, 1, 1000*i);
        tick();
        req_valid = '1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("rr_order", req_ready, 64'd1 << ((3+j)%4));
            if (j > 0) chk("no_bubble", dsp_a, ((2+j)%4)+1);
        end
        tick();
        req_valid = '0;
        repeat (8) tick();

        // skew: 3*(1+1)+100 = 106 then 4*(3+2)+200 = 220
        set_ops(1, 3, 1, 1, 100);
        set_ops(2, 4, 2, 3, 200);
        req_valid = 4'b0110;
        @(negedge clk);
        chk("skew_g1", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("skew_g2", req_ready, 4'b0100);
        tick();
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("skew_c_bubble_pre", dsp_c, 0);
        @(negedge clk);
        chk("skew_c100", dsp_c, 100);
        @(negedge clk);
        chk("skew_c200", dsp_c, 200);
        @(negedge clk);
        chk("skew_c_bubble_post", dsp_c, 0);
        chk("skew_rv1", rsp_valid, 4'b0010);
        chk("skew_p1", rsp_p, 106);
        @(negedge clk);
        chk("skew_rv2", rsp_valid, 4'b0100);
        chk("skew_p2", rsp_p, 220);
        repeat (4) tick();

        // drain: three ops in flight, then sched_en drops with requester 0 still valid
        set_ops(0, 1, 1, 1, 1);
        req_valid[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain_grant", req_ready, 4'b0001);
            tick();
        end
        sched_en = 0;
        @(negedge clk);
        chk("drain_ready_off", req_ready, 0);
        chk("drain_busy0", busy, 1);
        @(negedge clk);
        chk("drain_busy1", busy, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain_rv", rsp_valid, 4'b0001);
            chk("drain_p", rsp_p, 3);
            chk("drain_busy", busy, 1);
        end
        @(negedge clk);
        chk("drain_idle_busy", busy, 0);
        chk("drain_idle_rv", rsp_valid, 0);
        tick();
        req_valid = '0;

        // reset two cycles after an accept discards the op
        sched_en = 1;
        repeat (2) tick();
        issue(3, 7, 1, 1, 5);
        tick();
        rst_n = 0;
        @(negedge clk);
        chk("midrst_abd", {dsp_a, dsp_b, dsp_d}, 0);
        chk("midrst_p", rsp_p, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_no_rsp", rsp_valid, 0);
        end
        tick();
        issue(1, 2, 2, 2, 2);
        repeat (4) @(negedge clk);
        @(negedge clk);
        chk("post_rst_rv", rsp_valid, 4'b0010);
        chk("post_rst_p", rsp_p, 10);

        // requesters 0 and 1 contend; last grant is 1 so 0 goes first
        tick();
        set_ops(0, 1, 0, 0, 0);
        set_ops(1, 1, 0, 0, 0);
        req_valid = 4'b0011;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
`ifdef DSP_SCHED_PRIO_EN
            chk("prio_grant", req_ready, 4'b0001);
`else
            chk("alt_grant", req_ready, (j % 2 == 0) ? 1 : 2);
`endif
            tick();
        end
        req_valid = '0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
